branch_resolve_ctrl: RTL
========================

# branch_resolve_ctrl

Sequencing controller for the 4-entry branch predictor. It records every prediction issued in IF in a 4-deep in-flight queue, pairs each MEM-stage resolution with the oldest outstanding prediction, and trains the predictor. It also detects mispredictions, flushes wrong-path queue state, and throttles IF while the queue is full or recovering. It sits between the fetch/memory pipeline stages and the predictor's `bp` port.

## Interface

**Parameters**
- `DEPTH`, default 4: in-flight queue depth. Must be a power of two; only 4 is verified.

**Ports**
- `CLK` input 1: the single clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `if_valid` input 1: a branch was fetched this cycle and a prediction is being consumed.
- `if_index` input 2: predictor index of the fetched branch (drives `ifprindex`).
- `pr_result` input 1: predictor output for `if_index`.
- `alloc_ok` output 1: IF may allocate this cycle. When low, IF stalls and `if_valid` is ignored.
- `mm_valid` input 1: a branch resolves in MEM this cycle.
- `mm_taken` input 1: actual outcome (`ABtaken`).
- `mm_index` output 2: index of the queue head (drives `mmprindex`).
- `flush_all` input 1: external pipeline flush (jump/exception). Clears the queue.
- `upd_en` output 1: one-cycle predictor training strobe.
- `upd_index` output 2: index being trained.
- `upd_taken` output 1: outcome being trained.
- `mispredict` output 1: one-cycle pulse requesting a pipeline redirect.
- `inflight` output 3: current queue occupancy, 0..4.
- `proto_err` output 1: sticky error flag. Set when `mm_valid` arrives while the queue is empty.
- `stat_branches` output 16: resolved-branch count (see Configuration).
- `stat_mispred` output 16: mispredict count (see Configuration).

## Operation

- The queue entry is `{index[1:0], pred}`. It is written at the tail on an accepted allocation and read at the head on resolution.
- **Accepted allocation:** `if_valid && alloc_ok`.
- **alloc_ok** = `state==RUN && inflight<DEPTH`.
  - It is combinational from registered state only.
  - There is no same-cycle bypass: a pop in the same cycle does not make room for a push when full.
- **Resolution:** `mm_valid` with the queue non-empty.
  - Head is popped.
  - `mismatch` = `mm_taken != head.pred`.
- **Training:** every resolution registers `upd_en=1`, `upd_index=head.index`, `upd_taken=mm_taken`.
- **Mismatch:** register `mispredict=1`, clear the queue (head, tail and count to 0), and go to RECOVER. Any allocation in the same cycle is discarded as wrong-path.
- **FSM states:**
  - RUN → RECOVER on a mismatch.
  - RECOVER → RUN unconditionally after 1 cycle. `alloc_ok` is 0 in RECOVER.
  - `flush_all` clears the queue in either state and does not change state.
- **flush_all combined with a resolution in the same cycle:** training and mispredict detection still occur. The queue ends up empty.
- **mm_valid on an empty queue:** no pop, no update. `proto_err` is set and held until reset.
- Head and tail pointers are 2 bits and wrap modulo 4. Count is 3 bits.

## Timing

- **Reset values:**
  - `upd_en`, `upd_index`, `upd_taken`, `mispredict`, `proto_err` = 0.
  - `inflight` = 0 and the queue is empty.
  - State = RUN, so `alloc_ok` = 1.
  - Stats = 0.
- Reset is asserted asynchronously. Assertion mid-operation drops all in-flight entries immediately.
- `mm_index` is combinational from the head entry. It is 0 when the queue is empty.
- Latency from resolution to `upd_*` and `mispredict` is 1 cycle: both are valid in the cycle after `mm_valid`.
- After a mispredict, `alloc_ok` returns high 2 cycles after the resolving cycle.
- **Simultaneous push and pop while not full and without mismatch:** count is unchanged and both pointers advance.

## Configuration

- **`BPCTRL_STATS_EN` defined:**
  - `stat_branches` increments on every resolution.
  - `stat_mispred` increments on every mismatch.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared by `RST` only.
- **`BPCTRL_STATS_EN` undefined:** both ports are tied to 0 and no counter logic is built.

## Structure

- **Additions to `control_unit_types_pkg`:**
  - `bpq_entry_t` (packed struct `{logic [1:0] index; logic pred;}`).
  - `bpctrl_state_t` enum `{RUN, RECOVER}`.
  - `localparam BPQ_DEPTH = 4`.
- **Sub-module `bpq_fifo`:**
  - Synchronous-write queue of `bpq_entry_t`.
  - Ports: push, pop, clear, full, empty, count, head.
  - Uses the same `CLK`/`RST`.
- `branch_resolve_ctrl` contains the FSM, compare, training registers and stats.

## Test plan

- **Fill and block:** 4 pushes with indices 0,1,2,3 and preds 1,0,1,1 → `inflight`=4, `alloc_ok`=0. A 5th `if_valid` is ignored.
- **Correct resolve:** head {idx0, pred1} with `mm_valid=1`, `mm_taken=1` → next cycle `upd_en=1`, `upd_index=0`, `upd_taken=1`, `mispredict=0`, `inflight`=3, `mm_index`=1.
- **Mispredict:** head {idx1, pred0} with `mm_taken=1`, plus a concurrent push → next cycle `mispredict=1`, `inflight`=0, `alloc_ok`=0. The cycle after, `alloc_ok`=1.
- **Full push and pop together:** queue full, no mismatch → push is rejected and `inflight`=3. Pointer wrap is checked across 10 push/pop cycles with indices matching in order.
- **Protocol error and flush:** `mm_valid` on an empty queue → `proto_err`=1 sticky and `upd_en`=0. `flush_all` with 3 entries → `inflight`=0 while state stays RUN.
- **Stats and reset:** with `BPCTRL_STATS_EN`, 5 resolutions including 2 mismatches → `stat_branches`=5, `stat_mispred`=2. Asserting `RST` mid-stream returns all outputs to reset values in the same cycle.

Source files
------------

// File: rtl/control_unit_types_pkg.sv
// Shared types for the branch-predictor sequencing controller.
//   bpq_entry_t    : one in-flight prediction, {predictor index, predicted direction}
//   bpctrl_state_t : controller FSM state
//   BPQ_DEPTH      : default in-flight queue depth
package control_unit_types_pkg;

   localparam int BPQ_DEPTH = 4;

   typedef struct packed {
      logic [1:0] index;
      logic       pred;
   } bpq_entry_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } bpctrl_state_t;

endpackage

// File: rtl/bpq_fifo.sv
// In-flight prediction queue: synchronous-write circular buffer of bpq_entry_t.
// Ports:
//   CLK, RST  : clock, asynchronous active-high reset
//   push      : write push_data at the tail (ignored when full)
//   push_data : entry to write
//   pop       : drop the head entry (ignored when empty)
//   clear     : empty the queue; takes priority over push and pop
//   full, empty, count : occupancy status from registered state
//   head      : entry at the head (undefined content when empty)
module bpq_fifo
   import control_unit_types_pkg::*;
#(
   parameter int DEPTH = BPQ_DEPTH,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  bpq_entry_t    push_data,
   input  logic          pop,
   input  logic          clear,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   count,
   output bpq_entry_t    head
);

   bpq_entry_t    mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[head_q];

   // Push is gated on registered full only; a same-cycle pop never makes room.
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + 1'b1;
         if (do_pop)  head_d = head_q + 1'b1;
         count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge CLK) begin
      if (do_push) mem_q[tail_q] <= push_data;
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch-resolution sequencing controller for the 4-entry branch predictor.
// Records IF predictions in an in-flight queue, pairs MEM resolutions with the
// oldest prediction, trains the predictor, and flags/recovers from mispredicts.
// Ports:
//   CLK, RST                    : clock, asynchronous active-high reset
//   if_valid, if_index, pr_result : IF-stage prediction being consumed
//   alloc_ok                    : IF may allocate this cycle
//   mm_valid, mm_taken          : MEM-stage branch resolution
//   mm_index                    : predictor index of the queue head (0 when empty)
//   flush_all                   : external pipeline flush, empties the queue
//   upd_en, upd_index, upd_taken: registered training strobe
//   mispredict                  : registered redirect pulse
//   inflight                    : queue occupancy
//   proto_err                   : sticky, resolution seen with empty queue
//   stat_branches, stat_mispred : saturating counters
// Build option: define BPCTRL_STATS_EN to build the statistics counters;
// otherwise the stat ports are tied to 0.
//
// state   | meaning
// RUN     | normal operation, IF may allocate while the queue has room
// RECOVER | one cycle after a mispredict, IF allocation blocked
module branch_resolve_ctrl
   import control_unit_types_pkg::*;
#(
   parameter int DEPTH = BPQ_DEPTH,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          if_valid,
   input  logic [1:0]    if_index,
   input  logic          pr_result,
   output logic          alloc_ok,
   input  logic          mm_valid,
   input  logic          mm_taken,
   output logic [1:0]    mm_index,
   input  logic          flush_all,
   output logic          upd_en,
   output logic [1:0]    upd_index,
   output logic          upd_taken,
   output logic          mispredict,
   output logic [PW:0]   inflight,
   output logic          proto_err,
   output logic [15:0]   stat_branches,
   output logic [15:0]   stat_mispred
);

   bpctrl_state_t state_q, state_d;
   logic          upd_en_q, upd_en_d;
   logic [1:0]    upd_index_q, upd_index_d;
   logic          upd_taken_q, upd_taken_d;
   logic          mispredict_q, mispredict_d;
   logic          proto_err_q, proto_err_d;

   logic          q_full, q_empty;
   bpq_entry_t    q_head;
   logic          resolve, mismatch, push, clear;

   assign alloc_ok = (state_q == RUN) && !q_full;
   assign resolve  = mm_valid && !q_empty;
   assign mismatch = resolve && (mm_taken != q_head.pred);
   // Allocations coinciding with a mispredict or flush are wrong-path.
   assign push     = if_valid && alloc_ok && !mismatch && !flush_all;
   assign clear    = mismatch || flush_all;
   assign mm_index = q_empty ? 2'b00 : q_head.index;

   bpq_fifo #(.DEPTH(DEPTH)) u_bpq (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push),
      .push_data ({if_index, pr_result}),
      .pop       (resolve),
      .clear     (clear),
      .full      (q_full),
      .empty     (q_empty),
      .count     (inflight),
      .head      (q_head)
   );

   always_comb begin
      state_d      = state_q;
      upd_en_d     = resolve;
      upd_index_d  = upd_index_q;
      upd_taken_d  = upd_taken_q;
      mispredict_d = mismatch;
      proto_err_d  = proto_err_q || (mm_valid && q_empty);
      if (resolve) begin
         upd_index_d = q_head.index;
         upd_taken_d = mm_taken;
      end
      case (state_q)
         RUN:     if (mismatch) state_d = RECOVER;
         RECOVER: state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= RUN;
         upd_en_q     <= 1'b0;
         upd_index_q  <= 2'b00;
         upd_taken_q  <= 1'b0;
         mispredict_q <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         upd_en_q     <= upd_en_d;
         upd_index_q  <= upd_index_d;
         upd_taken_q  <= upd_taken_d;
         mispredict_q <= mispredict_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign upd_en     = upd_en_q;
   assign upd_index  = upd_index_q;
   assign upd_taken  = upd_taken_q;
   assign mispredict = mispredict_q;
   assign proto_err  = proto_err_q;

`ifdef BPCTRL_STATS_EN
   logic [15:0] stat_branches_q, stat_branches_d;
   logic [15:0] stat_mispred_q, stat_mispred_d;

   always_comb begin
      stat_branches_d = stat_branches_q;
      stat_mispred_d  = stat_mispred_q;
      if (resolve && (stat_branches_q != 16'hFFFF)) stat_branches_d = stat_branches_q + 16'd1;
      if (mismatch && (stat_mispred_q != 16'hFFFF)) stat_mispred_d = stat_mispred_q + 16'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stat_branches_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         stat_branches_q <= stat_branches_d;
         stat_mispred_q  <= stat_mispred_d;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispred  = stat_mispred_q;
`else
   assign stat_branches = 16'h0000;
   assign stat_mispred  = 16'h0000;
`endif

endmodule
